// File: rtl/regscan_pkg.sv
// rtl/regscan_pkg.sv - widths, FSM states and address stepping for regfile_scan_reader
// Optional feature macro: REGSCAN_SKIP_R0_EN (step over register 0).
package regscan_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

`ifdef REGSCAN_SKIP_R0_EN
  localparam bit SKIP_R0 = 1'b1;
`else
  localparam bit SKIP_R0 = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // NUM_REGS is a power of two, so plain ADDR_W-bit arithmetic gives the wrap.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] n;
    n = a + ADDR_W'(1);
    if (SKIP_R0 && n == '0) n = ADDR_W'(1);
    return n;
  endfunction

  function automatic logic [ADDR_W-1:0] prev_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] p;
    p = a - ADDR_W'(1);
    if (SKIP_R0 && p == '0) p = ADDR_W'(NUM_REGS - 1);
    return p;
  endfunction

endpackage

// File: rtl/regscan_out_stage.sv
// rtl/regscan_out_stage.sv - single-entry valid/ready holding register for data, address and last
module regscan_out_stage
  import regscan_pkg::*;
(
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_last,
  output logic              can_load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;

  assign can_load = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      addr_d  = in_addr;
      last_d  = in_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;

endmodule

// File: rtl/regfile_scan_reader.sv
// rtl/regfile_scan_reader.sv - walks a register range through one read port and streams tagged words
// Optional feature macro: REGSCAN_SKIP_R0_EN (register 0 is never emitted).
module regfile_scan_reader
  import regscan_pkg::*;
(
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] ctrl_readReg,
  input  logic [DATA_W-1:0] data_readReg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              empty_q, empty_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              can_load;
  logic              capture;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    empty_d = empty_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = (SKIP_R0 && first_reg == '0) ? ADDR_W'(1) : first_reg;
          end_d   = (SKIP_R0 && last_reg == '0) ? prev_addr(last_reg) : last_reg;
          empty_d = SKIP_R0 && first_reg == '0 && last_reg == '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (empty_q) begin
          state_d = DONE;
          cur_d   = '0;
        end else if (can_load) begin
          capture = 1'b1;
          if (cur_q == end_q) state_d = DRAIN;
          else                cur_d   = next_addr(cur_q);
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          state_d = DONE;
          cur_d   = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCAN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // cur_q doubles as the read-port address; it is parked at 0 whenever idle.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      end_q   <= '0;
      empty_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      empty_q <= empty_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  regscan_out_stage u_out_stage (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .load       (capture),
    .in_data    (data_readReg),
    .in_addr    (cur_q),
    .in_last    (cur_q == end_q),
    .can_load   (can_load),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last)
  );

  assign ctrl_readReg = cur_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// tb/tb_regfile_scan_reader.sv - randomized self-checking bench for regfile_scan_reader
module tb_regfile_scan_reader;
  import regscan_pkg::*;

`ifdef REGSCAN_SKIP_R0_EN
  localparam bit TB_SKIP = 1'b1;
`else
  localparam bit TB_SKIP = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              ctrl_reset;
  logic              start;
  logic [ADDR_W-1:0] first_reg, last_reg, ctrl_readReg, out_addr;
  logic [DATA_W-1:0] data_readReg, out_data;
  logic              out_valid, out_ready, out_last, busy, done;

  logic [DATA_W-1:0] regs [NUM_REGS];

  always #5 clock = ~clock;

  assign data_readReg = (ctrl_readReg == '0) ? '0 : regs[ctrl_readReg];

  regfile_scan_reader dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .start(start),
    .first_reg(first_reg), .last_reg(last_reg), .ctrl_readReg(ctrl_readReg),
    .data_readReg(data_readReg), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .done(done)
  );

  int vectors = 0;
  int errors  = 0;

  int          ob_addr[$];
  logic [31:0] ob_data[$];
  bit          ob_last[$];
  int          ob_cyc[$];
  int          exp_addr[$];
  int          done_cyc, done_count, busy_gap, stab_viol, busy_at_done;
  bit          timed_out, valid_seen;

  // Reference: addresses from first to last inclusive, wrapping mod NUM_REGS.
  task automatic build_exp(input int f, input int l);
    exp_addr.delete();
    for (int k = 0; k < NUM_REGS; k++) begin
      int a;
      a = (f + k) % NUM_REGS;
      if (!(TB_SKIP && a == 0)) exp_addr.push_back(a);
      if (a == l) break;
    end
  endtask

  function automatic logic [31:0] exp_data(input int a);
    return (a == 0) ? 32'h0 : regs[a];
  endfunction

  // Drives one scan and records what the consumer sees; called at posedge+1.
  // mode: 0 ready high, 1 random ready, 2 toggling ready, 3 ready low for cycles 0..5.
  task automatic do_scan(input int f, input int l, input int mode);
    bit          prev_hold;
    int          pa;
    logic [31:0] pd;
    bit          pl;
    ob_addr.delete(); ob_data.delete(); ob_last.delete(); ob_cyc.delete();
    done_cyc = -1; done_count = 0; busy_gap = 0; stab_viol = 0; busy_at_done = 0;
    timed_out = 1'b1; valid_seen = 1'b0; prev_hold = 1'b0; pa = 0; pd = '0; pl = 1'b0;
    for (int c = 0; c < 400; c++) begin
      start     = (c <= 1);
      first_reg = (c == 0) ? ADDR_W'(f) : ADDR_W'($urandom);
      last_reg  = (c == 0) ? ADDR_W'(l) : ADDR_W'($urandom);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom % 2) == 1;
        2:       out_ready = (c % 2) == 0;
        default: out_ready = (c >= 6);
      endcase
      @(negedge clock);
      if (prev_hold && (out_addr !== ADDR_W'(pa) || out_data !== pd || out_last !== pl))
        stab_viol++;
      prev_hold = out_valid && !out_ready;
      pa = int'(out_addr); pd = out_data; pl = out_last;
      if (out_valid) valid_seen = 1'b1;
      if (out_valid && out_ready) begin
        ob_addr.push_back(int'(out_addr)); ob_data.push_back(out_data);
        ob_last.push_back(out_last);       ob_cyc.push_back(c);
      end
      if (done) begin
        done_count++;
        if (done_cyc < 0) begin done_cyc = c; busy_at_done = busy; end
      end
      if (c >= 1 && done_cyc < 0 && !busy) busy_gap++;
      if (done_cyc >= 0 && c == done_cyc + 2) begin timed_out = 1'b0; break; end
      @(posedge clock); #1;
    end
    start = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    ctrl_reset = 1'b0; start = 1'b0; out_ready = 1'b0; first_reg = '0; last_reg = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({ctrl_readReg, out_valid, out_data, out_addr, out_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%0d v=%0b d=%h a=%0d l=%0b busy=%0b done=%0b, want all 0",
               ctrl_readReg, out_valid, out_data, out_addr, out_last, busy, done);
    end
    @(posedge clock); #1;
    ctrl_reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({ctrl_readReg, out_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got rd=%0d v=%0b busy=%0b done=%0b, want 0",
               ctrl_readReg, out_valid, busy, done);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_basic;
    int          ea[3] = '{5, 6, 7};
    logic [31:0] ed[3] = '{32'hDEADBEEF, 32'h1, 32'hFFFFFFFF};
    regs[5] = 32'hDEADBEEF; regs[6] = 32'h1; regs[7] = 32'hFFFFFFFF;
    do_scan(5, 7, 0);
    vectors++;
    if (timed_out || ob_addr.size() != 3) begin
      errors++; $display("FAIL basic_beats: got %0d beats timeout=%0b, want 3", ob_addr.size(), timed_out);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (ob_addr[i] !== ea[i] || ob_data[i] !== ed[i] || ob_last[i] !== (i == 2) || ob_cyc[i] !== 2 + i) begin
          errors++;
          $display("FAIL basic_beat%0d: got a=%0d d=%h l=%0b cyc=%0d, want a=%0d d=%h l=%0b cyc=%0d",
                   i, ob_addr[i], ob_data[i], ob_last[i], ob_cyc[i], ea[i], ed[i], i == 2, 2 + i);
        end
      end
    end
    vectors++;
    if (done_cyc !== 5 || done_count !== 1 || busy_at_done !== 0) begin
      errors++;
      $display("FAIL basic_done: got cyc=%0d pulses=%0d busy=%0d, want cyc=5 pulses=1 busy=0",
               done_cyc, done_count, busy_at_done);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
    build_exp(30, 1);
    do_scan(30, 1, 0);
    vectors++;
    if (timed_out || ob_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL wrap_beats: got %0d beats timeout=%0b, want %0d", ob_addr.size(), timed_out, exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        vectors++;
        if (ob_addr[i] !== exp_addr[i] || ob_data[i] !== exp_data(exp_addr[i]) ||
            ob_last[i] !== (i == exp_addr.size() - 1) || ob_cyc[i] !== 2 + i) begin
          errors++;
          $display("FAIL wrap_beat%0d: got a=%0d d=%h l=%0b cyc=%0d, want a=%0d d=%h cyc=%0d",
                   i, ob_addr[i], ob_data[i], ob_last[i], ob_cyc[i], exp_addr[i], exp_data(exp_addr[i]), 2 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    regs[3] = $urandom;
    do_scan(3, 3, 3);
    vectors++;
    if (timed_out || ob_addr.size() != 1) begin
      errors++; $display("FAIL bp_beats: got %0d beats timeout=%0b, want 1", ob_addr.size(), timed_out);
    end else if (ob_addr[0] !== 3 || ob_data[0] !== regs[3] || ob_last[0] !== 1'b1 || ob_cyc[0] !== 6) begin
      errors++;
      $display("FAIL bp_beat: got a=%0d d=%h l=%0b cyc=%0d, want a=3 d=%h l=1 cyc=6",
               ob_addr[0], ob_data[0], ob_last[0], ob_cyc[0], regs[3]);
    end
    vectors++;
    if (stab_viol !== 0 || done_cyc !== 7 || done_count !== 1) begin
      errors++;
      $display("FAIL bp_hold_done: got unstable=%0d done_cyc=%0d pulses=%0d, want 0/7/1",
               stab_viol, done_cyc, done_count);
    end
  endtask

  task automatic check_against_model(input string name);
    vectors++;
    if (timed_out || ob_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL %s_beats: got %0d beats timeout=%0b, want %0d", name, ob_addr.size(), timed_out, exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        vectors++;
        if (ob_addr[i] !== exp_addr[i] || ob_data[i] !== exp_data(exp_addr[i]) ||
            ob_last[i] !== (i == exp_addr.size() - 1)) begin
          errors++;
          $display("FAIL %s_beat%0d: got a=%0d d=%h l=%0b, want a=%0d d=%h", name, i,
                   ob_addr[i], ob_data[i], ob_last[i], exp_addr[i], exp_data(exp_addr[i]));
        end
      end
    end
    vectors++;
    if (busy_gap !== 0 || stab_viol !== 0 || done_count !== 1 || busy_at_done !== 0) begin
      errors++;
      $display("FAIL %s_ctrl: got busy_gap=%0d unstable=%0d pulses=%0d busy_at_done=%0d, want 0/0/1/0",
               name, busy_gap, stab_viol, done_count, busy_at_done);
    end
  endtask

  task automatic test_full_toggle;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
    build_exp(0, 31);
    do_scan(0, 31, 2);
    check_against_model("full");
    vectors++;
    if (ob_addr.size() != (TB_SKIP ? 31 : 32)) begin
      errors++; $display("FAIL full_count: got %0d, want %0d", ob_addr.size(), TB_SKIP ? 31 : 32);
    end
  endtask

  task automatic test_reset_mid;
    bit found = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
    first_reg = 5'd8; last_reg = 5'd20; out_ready = 1'b1; start = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clock);
      if (out_valid && out_addr == 5'd10) found = 1'b1;
      else begin @(posedge clock); #1; start = 1'b0; end
    end
    start = 1'b0;
    vectors++;
    if (!found) begin errors++; $display("FAIL rstmid_r10: got no beat for r10, want one"); end
    #1 ctrl_reset = 1'b0;
    #1;
    vectors++;
    if ({ctrl_readReg, out_valid, out_data, out_addr, out_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got v=%0b d=%h a=%0d busy=%0b done=%0b, want all 0",
               out_valid, out_data, out_addr, busy, done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      vectors++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_quiet: got done=%0b v=%0b, want 0/0", done, out_valid);
      end
    end
    @(posedge clock); #1;
    ctrl_reset = 1'b1;
    @(posedge clock); #1;
    build_exp(8, 20);
    do_scan(8, 20, 0);
    check_against_model("rstmid_fresh");
  endtask

  task automatic test_random;
    for (int n = 0; n < 6; n++) begin
      int f, l;
      for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
      f = $urandom_range(NUM_REGS - 1);
      l = (n == 0) ? f : $urandom_range(NUM_REGS - 1);
      build_exp(f, l);
      do_scan(f, l, 1);
      check_against_model($sformatf("rand%0d_%0d_%0d", n, f, l));
    end
  endtask

`ifdef REGSCAN_SKIP_R0_EN
  task automatic test_skip;
    do_scan(31, 2, 0);
    vectors++;
    if (ob_addr.size() != 3 || ob_addr[0] !== 31 || ob_addr[1] !== 1 || ob_addr[2] !== 2 || ob_last[2] !== 1'b1) begin
      errors++; $display("FAIL skip_31_2: got %0d beats %p, want 31,1,2", ob_addr.size(), ob_addr);
    end
    do_scan(0, 0, 0);
    vectors++;
    if (timed_out || valid_seen || done_count !== 1) begin
      errors++;
      $display("FAIL skip_0_0: got valid_seen=%0b pulses=%0d timeout=%0b, want 0/1/0",
               valid_seen, done_count, timed_out);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_full_toggle;
    test_reset_mid;
    test_random;
`ifdef REGSCAN_SKIP_R0_EN
    test_skip;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scan_reader.md
Name: regfile_scan_reader

Overview:
Read-side client of the 32x32 register file. On a start pulse it walks a register-address range through one register-file read port and captures each word. It then streams each word out on a valid/ready interface, tagged with its address. It sits between the register file's spare read port and display/debug consumers that need register snapshots, for example a VGA overlay or the game-state dump.

Parameters:
DATA_W, 32, register width.
ADDR_W, 5, register address width.
NUM_REGS, 32, register count (2**ADDR_W); address arithmetic is modulo NUM_REGS.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
ctrl_reset  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
first_reg  in  ADDR_W  first address of the scan; sampled with start.
last_reg  in  ADDR_W  last address of the scan, inclusive; sampled with start.
ctrl_readReg  out  ADDR_W  address to the register-file read port.
data_readReg  in  DATA_W  combinational read data for ctrl_readReg, same cycle.
out_valid  out  1  out_data, out_addr and out_last are valid.
out_ready  in  1  consumer accepts the current beat when out_valid is also high.
out_data  out  DATA_W  captured register word.
out_addr  out  ADDR_W  address the word came from.
out_last  out  1  this beat is the final beat of the scan.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE. All of the following are 0: ctrl_readReg, out_valid, out_data, out_addr, out_last, busy, done.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 latches first_reg into cur and last_reg into end, then goes to SCAN.
  - ctrl_readReg is held at 0.
- SCAN:
  - ctrl_readReg = cur.
  - Capture happens when the output stage is empty or being emptied this cycle (!out_valid || out_ready).
  - On capture: out_data<=data_readReg, out_addr<=cur, out_last<=(cur==end), out_valid<=1.
  - If cur==end the next state is DRAIN; otherwise cur<=cur+1 mod NUM_REGS.
  - Throughput is one beat per cycle when out_ready is held high.
- DRAIN: hold the output until out_valid && out_ready, then clear out_valid and go to DONE.
- DONE: done=1 for exactly one cycle, busy drops, return to IDLE.
- Latency: start asserted in cycle 0 gives SCAN in cycle 1 and the first out_valid in cycle 2.
- Backpressure:
  - While out_valid && !out_ready, out_data, out_addr and out_last are stable and cur does not advance.
  - ctrl_readReg stays at cur, so the word is re-read when capture resumes.
- Boundary conditions:
  - first_reg==last_reg: exactly one beat, with out_last=1.
  - first_reg>last_reg: the scan wraps, e.g. 30 to 1 yields addresses 30, 31, 0, 1.
  - Full scan (0 to 31) yields 32 beats.
- Register 0 is passed through as read; the register file returns 0 for it.
- A start while busy or in DONE is ignored; first_reg and last_reg changes are ignored while busy.
- Write coherence: a register-file write at the same edge as a capture is not forwarded. The captured value is the pre-write value.
- Reset mid-scan: immediate return to IDLE, out_valid=0, no done pulse, any partial beat is discarded.

Optional Feature:
Macro REGSCAN_SKIP_R0_EN.
- Defined: address 0 is never emitted; cur steps over 0 (31 goes to 1).
- If first_reg==0 the scan starts at 1.
- If the range is only register 0, there are no beats: go straight from SCAN to DONE, done pulses, and out_valid never rises.
- If last_reg==0, the beat for the preceding address carries out_last=1.
- Undefined: address 0 is included like any other register.

Decomposition:
- Package regscan_pkg holds the state enum (IDLE, SCAN, DRAIN, DONE), ADDR_W, DATA_W and NUM_REGS, plus a next-address function with wrap and the optional skip.
- One sub-module, regscan_out_stage: a single-entry valid/ready holding register for data, address and last.
- The top level holds the FSM and address counter.

Test Plan:
1. Preload r5=0xDEADBEEF, r6=1, r7=0xFFFFFFFF; scan 5 to 7 with out_ready=1 -> beats (5,0xDEADBEEF,0), (6,1,0), (7,0xFFFFFFFF,1) on consecutive cycles from cycle 2; done one cycle after the last beat.
2. Scan 30 to 1 with r30..r1 preloaded -> addresses 30, 31, 0, 1 in order; r0 data=0; out_last only on address 1.
3. Scan 3 to 3; hold out_ready=0 for 4 cycles -> out_valid stays high with out_addr=3 stable; accepted on the first cycle out_ready=1; done follows.
4. Toggle out_ready 1,0,1,0 during scan 0 to 31 -> exactly 32 beats, no duplicated or skipped address, busy high throughout.
5. Deassert ctrl_reset during the beat for r10 of scan 8 to 20 -> outputs 0 immediately, no done pulse; a fresh start afterwards works normally.
6. With REGSCAN_SKIP_R0_EN: scan 31 to 2 -> addresses 31, 1, 2; scan 0 to 0 -> zero beats and a done pulse.
